// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types and constants for elastic stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/skid_buffer_ctrl.sv
// ============================================================================
// Module      : skid_buffer_ctrl
// Description : Occupancy FSM for the two-entry skid buffer; registered
//               handshake outputs plus datapath load/select strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic sel_skid
);

    skid_state_t r_state;
    skid_state_t w_next;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        w_in_xfer;
    logic        w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            SKID_EMPTY: if (w_in_xfer) w_next = SKID_BUSY;
            SKID_BUSY: begin
                if (w_in_xfer && !w_out_xfer)      w_next = SKID_FULL;
                else if (!w_in_xfer && w_out_xfer) w_next = SKID_EMPTY;
            end
            SKID_FULL:  if (w_out_xfer) w_next = SKID_BUSY;
            default:    w_next = SKID_EMPTY;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode so the
    // upstream never sees a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != SKID_FULL);
            r_out_valid <= (w_next != SKID_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sel_skid  = (r_state == SKID_FULL);
    assign load_main = !flush &&
                       (((r_state == SKID_EMPTY) && w_in_xfer) ||
                        ((r_state == SKID_BUSY)  && w_in_xfer && w_out_xfer) ||
                        ((r_state == SKID_FULL)  && w_out_xfer));
    assign load_skid = !flush && (r_state == SKID_BUSY) && w_in_xfer && !w_out_xfer;

endmodule

`default_nettype wire

// File: rtl/skid_buffer.sv
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry elastic pipeline stage with fully registered
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer
    import pipe_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WORD_WIDTH-1:0] r_main;
    logic [WORD_WIDTH-1:0] r_skid;
    logic [WORD_WIDTH-1:0] w_main_d;
    logic                  w_load_main;
    logic                  w_load_skid;
    logic                  w_sel_skid;

    skid_buffer_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_main (w_load_main),
        .load_skid (w_load_skid),
        .sel_skid  (w_sel_skid)
    );

    // Draining from FULL refills main from the skid; otherwise main takes input.
    assign w_main_d = w_sel_skid ? r_skid : in_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else begin
            if (w_load_main) r_main <= w_main_d;
            if (w_load_skid) r_skid <= in_data;
        end
    end

    assign out_data = r_main;

endmodule

`default_nettype wire

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
Elastic two-entry pipeline stage with a valid/ready handshake on both sides. It is the downstream-facing counterpart of the plain enable-gated stage registers: it absorbs backpressure so that a stall never combinationally ripples upstream. All outputs, including in_ready, are registered. It sits between core pipeline stages and at the instruction-fetch and LSU boundaries.

Parameters:
WORD_WIDTH, 32, payload width in bits (must be >= 1)
RESET_VALUE, 0, value driven on out_data after reset or flush (WORD_WIDTH bits)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous discard of all held entries
in_data  input  WORD_WIDTH  upstream payload
in_valid  input  1  upstream offers in_data
in_ready  output  1  buffer accepts this cycle (registered)
out_data  output  WORD_WIDTH  downstream payload (registered)
out_valid  output  1  out_data is valid (registered)
out_ready  input  1  downstream accepts this cycle

Behaviour:
- Single clock domain. Reset is synchronous and active-high (rst). rst has priority over flush; flush has priority over handshakes.
- Reset or flush state: EMPTY, out_valid=0, in_ready=1, out_data=RESET_VALUE, skid register=RESET_VALUE.
- Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge.
- Storage: main register (drives out_data) and skid register.
- FSM states:
  - EMPTY: both registers free.
  - BUSY: main register full, skid free.
  - FULL: both registers full.
- Transitions:
  - EMPTY + in transfer -> BUSY; main <= in_data.
  - BUSY + in only -> FULL; skid <= in_data.
  - BUSY + out only -> EMPTY.
  - BUSY + in and out -> BUSY; main <= in_data.
  - FULL + out -> BUSY; main <= skid.
  - FULL + in_valid is impossible to accept, because in_ready=0.
  - Any other combination: hold.
- Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL). Both are derived from registered state only, with no combinational path from out_ready or in_valid.
- Latency: 1 cycle, from an in transfer to out_valid when EMPTY.
- Throughput: 1 word/cycle in steady state with out_ready=1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- in_valid while in_ready=0: the word is not taken; upstream must hold it.
- Freed registers keep their stale contents except on rst or flush.
- flush coinciding with in_valid: the input word is discarded, and in_ready reads 1 in the next cycle.
- Reset mid-operation: all held words are lost; outputs take their reset values on the next edge.
- No X propagation: out_data is never X after the first reset.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {SKID_EMPTY, SKID_BUSY, SKID_FULL}.
  - Handshake helper constant SKID_DEPTH = 2.
- Sub-module skid_buffer_ctrl (FSM only):
  - Inputs: clk, rst, flush, in_valid, out_ready.
  - Outputs: in_ready, out_valid, load_main, load_skid, sel_skid.
- The datapath (two enable-gated registers plus a 2:1 mux in front of main) stays in skid_buffer.

Test Plan:
1. rst=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, in_ready=1, out_data=0x00000000 throughout.
2. Stream 0x1,0x2,0x3,0x4 on consecutive cycles, out_ready=1 -> out_data 0x1..0x4 on cycles 1..4; out_valid stays high with no bubbles; in_ready stays 1.
3. Send 0xA then 0xB, hold out_ready=0 -> after 2 edges state FULL, in_ready=0, out_data=0xA held. Offer 0xC while stalled -> not accepted. Raise out_ready for 3 cycles -> outputs 0xA, 0xB, 0xC in order.
4. FULL with 0x5,0x6 held; assert flush together with in_valid, in_data=0x7 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VALUE; 0x7 never appears.
5. BUSY holding 0x10 with in_valid=1, in_data=0x11, out_ready=1 on the same edge -> stays BUSY, out_data=0x11, in_ready=1.
6. Randomized in_valid/out_ready (50%) for 1000 cycles, scoreboard checked -> output sequence equals input sequence. Assertions:
   - out_data is stable while stalled.
   - out_valid is never 1 in EMPTY.
   - in_ready and out_valid have no combinational dependency on in_valid or out_ready.
